controlador_busca: RTL and testbench

- Instruction-fetch sequencer sitting on the control side of the 16-bit program counter.
- Reads the current PC value and issues a memory read handshake at that address.
- Hands the fetched word to the downstream consumer with a valid/accept handshake.
- Drives the PC's load/increment controls to step sequentially, take an absolute jump, or halt.

---
 rtl/controlador_busca.sv | 118 +++++++++++
 tb/tb_controlador_busca.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_busca.sv
// Instruction-fetch sequencer: reads the word at the current PC, hands it to
// the consumer with a valid/accept handshake, then steps, jumps or halts the PC.
module controlador_busca #(
    parameter int          LIMITE_ESPERA = 8,
    parameter logic [3:0]  OPCODE_SALTO  = 4'hF,
    parameter logic [15:0] INSTR_PARAR   = 16'h0000
) (
    input  logic        relogio,
    input  logic        reiniciar,
    input  logic [15:0] pc_atual,
    output logic [15:0] pc_entrada,
    output logic        pc_carregar,
    output logic        pc_soma,
    output logic [15:0] mem_endereco,
    output logic        mem_ler,
    input  logic        mem_pronto,
    input  logic [15:0] mem_dado,
    output logic [15:0] instrucao,
    output logic        instrucao_valida,
    input  logic        aceitar,
    output logic        parado,
    output logic        erro
);

    typedef enum logic [1:0] {
        BUSCA   = 2'd0,
        ENTREGA = 2'd1,
        AVANCA  = 2'd2,
        PARADO  = 2'd3
    } estado_t;

    // The last wait cycle is the one where the counter would reach the limit.
    localparam logic [7:0] ULTIMA_ESPERA = 8'(LIMITE_ESPERA - 1);

    estado_t     estado, estado_prox;
    logic [7:0]  contador, contador_prox;
    logic [15:0] instrucao_prox;
    logic [15:0] pc_entrada_prox;
    logic        pc_carregar_prox;
    logic        pc_soma_prox;
    logic        erro_prox;

    // Next-state and next-register values; strobes default low so they only live in AVANCA.
    always_comb begin
        estado_prox      = estado;
        contador_prox    = contador;
        instrucao_prox   = instrucao;
        pc_entrada_prox  = pc_entrada;
        pc_carregar_prox = 1'b0;
        pc_soma_prox     = 1'b0;
        erro_prox        = erro;
        case (estado)
            BUSCA: begin
                if (mem_pronto) begin
                    instrucao_prox = mem_dado;
                    contador_prox  = 8'd0;
                    estado_prox    = ENTREGA;
                end else if (contador == ULTIMA_ESPERA) begin
                    erro_prox     = 1'b1;
                    contador_prox = 8'd0;
                    estado_prox   = PARADO;
                end else begin
                    contador_prox = contador + 8'd1;
                end
            end
            ENTREGA: begin
                if (aceitar) begin
                    if (instrucao == INSTR_PARAR) begin
                        estado_prox = PARADO;
                    end else if (instrucao[15:12] == OPCODE_SALTO) begin
                        pc_entrada_prox  = {4'b0000, instrucao[11:0]};
                        pc_carregar_prox = 1'b1;
                        estado_prox      = AVANCA;
                    end else begin
                        pc_soma_prox = 1'b1;
                        estado_prox  = AVANCA;
                    end
                end
            end
            AVANCA: begin
                estado_prox = BUSCA;
            end
            PARADO: begin
                estado_prox = PARADO;
            end
            default: begin
                estado_prox = BUSCA;
            end
        endcase
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge relogio) begin
        if (reiniciar) begin
            estado      <= BUSCA;
            contador    <= 8'd0;
            instrucao   <= 16'h0000;
            pc_entrada  <= 16'h0000;
            pc_carregar <= 1'b0;
            pc_soma     <= 1'b0;
            erro        <= 1'b0;
        end else begin
            estado      <= estado_prox;
            contador    <= contador_prox;
            instrucao   <= instrucao_prox;
            pc_entrada  <= pc_entrada_prox;
            pc_carregar <= pc_carregar_prox;
            pc_soma     <= pc_soma_prox;
            erro        <= erro_prox;
        end
    end

    assign mem_endereco     = pc_atual;
    assign mem_ler          = (estado == BUSCA);
    assign instrucao_valida = (estado == ENTREGA);
    assign parado           = (estado == PARADO);

endmodule

// File: tb/tb_controlador_busca.sv
// Self-checking bench for the fetch sequencer, with a behavioural program
// counter around it and a reference PC model computed from the fetched words.
module tb_controlador_busca;

    localparam int          LIM    = 8;
    localparam logic [3:0]  OPCODE = 4'hF;
    localparam logic [15:0] PARAR  = 16'h0000;

    logic        relogio = 1'b0;
    logic        reiniciar;
    logic [15:0] pc_atual;
    logic [15:0] pc_entrada;
    logic        pc_carregar;
    logic        pc_soma;
    logic [15:0] mem_endereco;
    logic        mem_ler;
    logic        mem_pronto;
    logic [15:0] mem_dado;
    logic [15:0] instrucao;
    logic        instrucao_valida;
    logic        aceitar;
    logic        parado;
    logic        erro;

    logic        pc_forcar;
    logic [15:0] pc_forcar_val;

    int total = 0;
    int bad   = 0;

    controlador_busca #(
        .LIMITE_ESPERA(LIM),
        .OPCODE_SALTO (OPCODE),
        .INSTR_PARAR  (PARAR)
    ) dut (
        .relogio         (relogio),
        .reiniciar       (reiniciar),
        .pc_atual        (pc_atual),
        .pc_entrada      (pc_entrada),
        .pc_carregar     (pc_carregar),
        .pc_soma         (pc_soma),
        .mem_endereco    (mem_endereco),
        .mem_ler         (mem_ler),
        .mem_pronto      (mem_pronto),
        .mem_dado        (mem_dado),
        .instrucao       (instrucao),
        .instrucao_valida(instrucao_valida),
        .aceitar         (aceitar),
        .parado          (parado),
        .erro            (erro)
    );

    // Free-running clock.
    always #5 relogio = ~relogio;

    // Program counter driven by the sequencer's strobes, with a preload hook for the bench.
    always @(posedge relogio) begin
        if (reiniciar)        pc_atual <= 16'h0000;
        else if (pc_forcar)   pc_atual <= pc_forcar_val;
        else if (pc_carregar) pc_atual <= pc_entrada;
        else if (pc_soma)     pc_atual <= pc_atual + 16'h0001;
    end

    task automatic ciclo();
        @(posedge relogio);
        #1;
    endtask

    task automatic reset_dut();
        reiniciar = 1'b1;
        ciclo();
        reiniciar = 1'b0;
    endtask

    task automatic test_reset();
        reiniciar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_pronto = 1'($urandom);
            aceitar    = 1'($urandom);
            mem_dado   = 16'($urandom);
            ciclo();
            total++;
            if ({mem_ler, instrucao_valida, parado, erro, pc_soma, pc_carregar} !== 6'b100000 ||
                instrucao !== 16'h0000 || pc_entrada !== 16'h0000 || mem_endereco !== 16'h0000) begin
                bad++;
                $display("[TB] FAIL reset_state: flags=%b instr=%h pc_entrada=%h addr=%h want flags=100000 instr=0000 pc_entrada=0000 addr=0000",
                         {mem_ler, instrucao_valida, parado, erro, pc_soma, pc_carregar}, instrucao, pc_entrada, mem_endereco);
            end
        end
        reiniciar = 1'b0;
    endtask

    task automatic test_sequential();
        reset_dut();
        mem_pronto = 1'b1;
        mem_dado   = 16'h1234;
        aceitar    = 1'b1;
        for (int k = 0; k < 9; k++) begin
            total++;
            if (pc_soma !== (k % 3 == 2) || pc_carregar !== 1'b0) begin
                bad++;
                $display("[TB] FAIL seq_strobe k=%0d: soma=%b carregar=%b want soma=%b carregar=0", k, pc_soma, pc_carregar, (k % 3 == 2));
            end
            if (k % 3 == 0) begin
                total++;
                if (mem_ler !== 1'b1 || mem_endereco !== 16'(k / 3)) begin
                    bad++;
                    $display("[TB] FAIL seq_addr k=%0d: ler=%b addr=%h want ler=1 addr=%h", k, mem_ler, mem_endereco, 16'(k / 3));
                end
            end
            if (k % 3 == 1) begin
                total++;
                if (instrucao_valida !== 1'b1 || instrucao !== 16'h1234) begin
                    bad++;
                    $display("[TB] FAIL seq_instr k=%0d: valida=%b instr=%h want valida=1 instr=1234", k, instrucao_valida, instrucao);
                end
            end
            ciclo();
        end
    endtask

    task automatic test_jump();
        reset_dut();
        mem_pronto = 1'b1;
        aceitar    = 1'b1;
        for (int k = 0; k < 13; k++) begin
            mem_dado = (k == 9) ? 16'hF0A5 : 16'h1234;
            if (k == 10) begin
                total++;
                if (instrucao !== 16'hF0A5 || instrucao_valida !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL jump_instr: instr=%h valida=%b want F0A5 1", instrucao, instrucao_valida);
                end
            end
            if (k == 11) begin
                total++;
                if (pc_carregar !== 1'b1 || pc_soma !== 1'b0 || pc_entrada !== 16'h00A5) begin
                    bad++;
                    $display("[TB] FAIL jump_load: carregar=%b soma=%b pc_entrada=%h want 1 0 00A5", pc_carregar, pc_soma, pc_entrada);
                end
            end
            if (k == 12) begin
                total++;
                if (pc_carregar !== 1'b0 || pc_soma !== 1'b0 || mem_ler !== 1'b1 || mem_endereco !== 16'h00A5) begin
                    bad++;
                    $display("[TB] FAIL jump_target: carregar=%b soma=%b ler=%b addr=%h want 0 0 1 00A5", pc_carregar, pc_soma, mem_ler, mem_endereco);
                end
            end
            ciclo();
        end
    endtask

    task automatic test_stall();
        logic [15:0] w;
        int pulsos;
        w = 16'($urandom_range(16'h0001, 16'hEFFF));
        reset_dut();
        mem_pronto = 1'b1;
        mem_dado   = w;
        aceitar    = 1'b0;
        ciclo();
        for (int i = 0; i < 5; i++) begin
            mem_pronto = 1'($urandom);
            mem_dado   = 16'($urandom);
            total++;
            if (instrucao_valida !== 1'b1 || instrucao !== w || pc_soma !== 1'b0 || pc_carregar !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold i=%0d: valida=%b instr=%h soma=%b carregar=%b want 1 %h 0 0", i, instrucao_valida, instrucao, pc_soma, pc_carregar, w);
            end
            ciclo();
        end
        mem_pronto = 1'b0;
        aceitar    = 1'b1;
        pulsos     = 0;
        for (int i = 0; i < 4; i++) begin
            ciclo();
            aceitar = 1'b0;
            if (pc_soma === 1'b1) pulsos++;
        end
        total++;
        if (pulsos !== 1 || mem_endereco !== 16'h0001) begin
            bad++;
            $display("[TB] FAIL stall_release: pulses=%0d addr=%h want 1 0001", pulsos, mem_endereco);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        mem_pronto = 1'b0;
        aceitar    = 1'b0;
        for (int k = 0; k < LIM; k++) begin
            total++;
            if (mem_ler !== 1'b1 || parado !== 1'b0 || erro !== 1'b0) begin
                bad++;
                $display("[TB] FAIL timeout_wait k=%0d: ler=%b parado=%b erro=%b want 1 0 0", k, mem_ler, parado, erro);
            end
            ciclo();
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (erro !== 1'b1 || parado !== 1'b1 || mem_ler !== 1'b0 || instrucao_valida !== 1'b0 || pc_soma !== 1'b0 || pc_carregar !== 1'b0) begin
                bad++;
                $display("[TB] FAIL timeout_halt i=%0d: erro=%b parado=%b ler=%b valida=%b soma=%b carregar=%b want 1 1 0 0 0 0",
                         i, erro, parado, mem_ler, instrucao_valida, pc_soma, pc_carregar);
            end
            mem_pronto = 1'b1;
            aceitar    = 1'b1;
            mem_dado   = 16'h1234;
            ciclo();
        end
        reset_dut();
        total++;
        if (erro !== 1'b0 || parado !== 1'b0 || mem_ler !== 1'b1 || mem_endereco !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL timeout_clear: erro=%b parado=%b ler=%b addr=%h want 0 0 1 0000", erro, parado, mem_ler, mem_endereco);
        end
        ciclo();
        total++;
        if (instrucao_valida !== 1'b1 || instrucao !== 16'h1234) begin
            bad++;
            $display("[TB] FAIL timeout_restart: valida=%b instr=%h want 1 1234", instrucao_valida, instrucao);
        end
    endtask

    task automatic test_late_data();
        reset_dut();
        mem_pronto = 1'b0;
        aceitar    = 1'b0;
        for (int k = 0; k < LIM - 1; k++) ciclo();
        mem_pronto = 1'b1;
        mem_dado   = 16'h4321;
        ciclo();
        mem_pronto = 1'b0;
        total++;
        if (erro !== 1'b0 || parado !== 1'b0 || instrucao_valida !== 1'b1 || instrucao !== 16'h4321) begin
            bad++;
            $display("[TB] FAIL late_data: erro=%b parado=%b valida=%b instr=%h want 0 0 1 4321", erro, parado, instrucao_valida, instrucao);
        end
    endtask

    task automatic test_halt();
        reset_dut();
        mem_pronto = 1'b1;
        mem_dado   = PARAR;
        aceitar    = 1'b1;
        ciclo();
        ciclo();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (parado !== 1'b1 || pc_soma !== 1'b0 || pc_carregar !== 1'b0 || mem_ler !== 1'b0 || mem_endereco !== 16'h0000) begin
                bad++;
                $display("[TB] FAIL halt i=%0d: parado=%b soma=%b carregar=%b ler=%b addr=%h want 1 0 0 0 0000",
                         i, parado, pc_soma, pc_carregar, mem_ler, mem_endereco);
            end
            ciclo();
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        mem_pronto = 1'b1;
        mem_dado   = 16'h1234;
        aceitar    = 1'b1;
        for (int i = 0; i < 3; i++) ciclo();
        aceitar = 1'b0;
        ciclo();
        aceitar   = 1'b1;
        reiniciar = 1'b1;
        ciclo();
        reiniciar = 1'b0;
        total++;
        if (pc_soma !== 1'b0 || pc_carregar !== 1'b0 || mem_ler !== 1'b1 || instrucao_valida !== 1'b0 ||
            mem_endereco !== 16'h0000 || instrucao !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_mid: soma=%b carregar=%b ler=%b valida=%b addr=%h instr=%h want 0 0 1 0 0000 0000",
                     pc_soma, pc_carregar, mem_ler, instrucao_valida, mem_endereco, instrucao);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        mem_pronto    = 1'b0;
        aceitar       = 1'b0;
        pc_forcar     = 1'b1;
        pc_forcar_val = 16'hFFFF;
        ciclo();
        pc_forcar = 1'b0;
        total++;
        if (mem_ler !== 1'b1 || mem_endereco !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL wrap_start: ler=%b addr=%h want 1 FFFF", mem_ler, mem_endereco);
        end
        mem_pronto = 1'b1;
        mem_dado   = 16'h5A5A;
        aceitar    = 1'b1;
        ciclo();
        ciclo();
        total++;
        if (pc_soma !== 1'b1 || pc_carregar !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrap_strobe: soma=%b carregar=%b want 1 0", pc_soma, pc_carregar);
        end
        ciclo();
        total++;
        if (mem_ler !== 1'b1 || mem_endereco !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL wrap_addr: ler=%b addr=%h want 1 0000", mem_ler, mem_endereco);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] w;
        logic [15:0] alvo;
        int d;
        int a;
        int tipo;
        reset_dut();
        exp_pc = 16'h0000;
        for (int n = 0; n < 40; n++) begin
            tipo = $urandom_range(0, 9);
            if (tipo < 3)       w = {OPCODE, 12'($urandom)};
            else if (tipo == 3) w = PARAR;
            else                w = 16'($urandom);
            d = $urandom_range(0, LIM - 1);
            a = $urandom_range(0, 3);
            mem_pronto = 1'b0;
            total++;
            if ({mem_ler, pc_soma, pc_carregar, parado} !== 4'b1000 || mem_endereco !== exp_pc) begin
                bad++;
                $display("[TB] FAIL rnd_fetch n=%0d: flags=%b addr=%h want 1000 %h", n, {mem_ler, pc_soma, pc_carregar, parado}, mem_endereco, exp_pc);
            end
            for (int i = 0; i < d; i++) begin
                aceitar = 1'($urandom);
                ciclo();
                total++;
                if ({mem_ler, erro, instrucao_valida} !== 3'b100) begin
                    bad++;
                    $display("[TB] FAIL rnd_wait n=%0d: ler/erro/valida=%b want 100", n, {mem_ler, erro, instrucao_valida});
                end
            end
            mem_pronto = 1'b1;
            mem_dado   = w;
            aceitar    = 1'($urandom);
            ciclo();
            aceitar = 1'b0;
            for (int i = 0; i <= a; i++) begin
                total++;
                if ({instrucao_valida, pc_soma, pc_carregar} !== 3'b100 || instrucao !== w) begin
                    bad++;
                    $display("[TB] FAIL rnd_deliver n=%0d: flags=%b instr=%h want 100 %h", n, {instrucao_valida, pc_soma, pc_carregar}, instrucao, w);
                end
                mem_pronto = 1'($urandom);
                mem_dado   = 16'($urandom);
                if (i == a) aceitar = 1'b1;
                ciclo();
            end
            aceitar    = 1'($urandom);
            mem_pronto = 1'($urandom);
            if (w == PARAR) begin
                total++;
                if ({parado, pc_soma, pc_carregar, mem_ler} !== 4'b1000 || mem_endereco !== exp_pc) begin
                    bad++;
                    $display("[TB] FAIL rnd_halt n=%0d: flags=%b addr=%h want 1000 %h", n, {parado, pc_soma, pc_carregar, mem_ler}, mem_endereco, exp_pc);
                end
                reset_dut();
                exp_pc = 16'h0000;
            end else if (w[15:12] == OPCODE) begin
                alvo = {4'h0, w[11:0]};
                total++;
                if ({pc_carregar, pc_soma} !== 2'b10 || pc_entrada !== alvo) begin
                    bad++;
                    $display("[TB] FAIL rnd_jump n=%0d: carregar/soma=%b pc_entrada=%h want 10 %h", n, {pc_carregar, pc_soma}, pc_entrada, alvo);
                end
                exp_pc = alvo;
                ciclo();
            end else begin
                total++;
                if ({pc_carregar, pc_soma} !== 2'b01) begin
                    bad++;
                    $display("[TB] FAIL rnd_step n=%0d: carregar/soma=%b want 01", n, {pc_carregar, pc_soma});
                end
                exp_pc = exp_pc + 16'h0001;
                ciclo();
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        reiniciar     = 1'b1;
        mem_pronto    = 1'b0;
        mem_dado      = 16'h0000;
        aceitar       = 1'b0;
        pc_forcar     = 1'b0;
        pc_forcar_val = 16'h0000;
        #2;
        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_timeout();
        test_late_data();
        test_halt();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
